// File: rtl/qif_synapse.sv
// Event-driven synaptic current source: weighted spike events are queued in a small FIFO,
// summed into a saturating signed accumulator that decays toward zero, and presented as I_syn.
module qif_synapse #(
  parameter int DEPTH        = 4,
  parameter int DECAY_PERIOD = 16,
  parameter int DECAY_SHIFT  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      ev_valid,
  input  logic signed [7:0]         ev_weight,
  output logic                      ev_ready,
  output logic signed [7:0]         I_syn,
  output logic [$clog2(DEPTH):0]    ev_count,
  output logic                      sat
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DECAY_PERIOD - 1);
  localparam logic signed [8:0] SUM_MAX = 9'sd127;
  localparam logic signed [8:0] SUM_MIN = -9'sd128;

  // One decay step; the unit step toward zero keeps small values from sticking at +/-1.
  function automatic logic signed [7:0] decay_step(input logic signed [7:0] a);
    logic signed [7:0] d;
    d = a >>> DECAY_SHIFT;
    if (d != 8'sd0)     return a - d;
    else if (a > 8'sd0) return a - 8'sd1;
    else if (a < 8'sd0) return a + 8'sd1;
    else                return a;
  endfunction

  // Returns {clamped, result}: 9-bit sum saturated into the 8-bit signed range.
  function automatic logic [8:0] sat_add(input logic signed [7:0] a,
                                         input logic signed [7:0] b);
    logic signed [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s > SUM_MAX)      return {1'b1, 8'h7F};
    else if (s < SUM_MIN) return {1'b1, 8'h80};
    else                  return {1'b0, s[7:0]};
  endfunction

  logic signed [7:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic signed [7:0] acc_q, acc_d;
  logic              sat_q, sat_d;

  logic              push, pop, tick;
  logic signed [7:0] head_w, acc_decayed;
  logic [8:0]        add_res;

  assign ev_ready = (count_q != CW'(DEPTH));
  assign push     = ev_valid && ev_ready;
  assign pop      = ena && (count_q != '0);
  assign tick     = ena && (presc_q == PRESC_LAST);
  assign head_w   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    presc_d     = presc_q;
    acc_d       = acc_q;
    sat_d       = 1'b0;
    acc_decayed = acc_q;
    add_res     = '0;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (ena) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) acc_decayed = decay_step(acc_q);
      // Decay lands first, then the popped weight is added with saturation.
      if (pop) begin
        add_res = sat_add(acc_decayed, head_w);
        sat_d   = add_res[8];
        acc_d   = add_res[7:0];
      end else begin
        acc_d = acc_decayed;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      presc_q  <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
    end
  end

  // Event storage carries data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ev_weight;
  end

  assign I_syn    = acc_q;
  assign ev_count = count_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_qif_synapse.sv
// Directed bench for qif_synapse: an integer/queue reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_qif_synapse;

  localparam int DEPTH = 4;
  localparam int P     = 16;
  localparam int SHIFT = 3;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic              ev_valid;
  logic signed [7:0] ev_weight;
  logic              ev_ready;
  logic signed [7:0] I_syn;
  logic [2:0]        ev_count;
  logic              sat;

  qif_synapse #(.DEPTH(DEPTH), .DECAY_PERIOD(P), .DECAY_SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ev_valid(ev_valid), .ev_weight(ev_weight),
    .ev_ready(ev_ready), .I_syn(I_syn), .ev_count(ev_count), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: event queue, integer current, enabled-cycle counter.
  int m_q[$];
  int m_acc   = 0;
  int m_sat   = 0;
  int m_presc = 0;

  function automatic int floor_div8(input int a);
    if (a >= 0) return a / (1 << SHIFT);
    return -((-a + (1 << SHIFT) - 1) / (1 << SHIFT));
  endfunction

  function automatic int decay(input int a);
    int d;
    d = floor_div8(a);
    if (d != 0) return a - d;
    if (a > 0)  return a - 1;
    if (a < 0)  return a + 1;
    return 0;
  endfunction

  task automatic model_edge();
    int  sz, w, s;
    bit  do_push, do_pop, tick;
    sz      = m_q.size();
    do_push = ev_valid && (sz < DEPTH);
    do_pop  = ena && (sz != 0);
    w = 0;
    if (do_pop) w = m_q.pop_front();
    if (do_push) m_q.push_back(int'(ev_weight));
    m_sat = 0;
    if (ena) begin
      tick    = (m_presc == P - 1);
      m_presc = (m_presc + 1) % P;
      if (tick) m_acc = decay(m_acc);
      if (do_pop) begin
        s = m_acc + w;
        if (s > 127)       begin m_acc = 127;  m_sat = 1; end
        else if (s < -128) begin m_acc = -128; m_sat = 1; end
        else m_acc = s;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_acc = 0; m_sat = 0; m_presc = 0;
    end else begin
      model_edge();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("I_syn", int'(I_syn), m_acc);
    chk("ev_count", int'(ev_count), m_q.size());
    chk("ev_ready", int'(ev_ready), (m_q.size() < DEPTH) ? 1 : 0);
    chk("sat", int'(sat), m_sat);
  end

  // Called at a falling edge: inputs are applied to the next rising edge, returns at the following falling edge.
  task automatic step(input bit v, input int w, input bit e);
    ev_valid  = v;
    ev_weight = 8'(w);
    ena       = e;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit e);
    repeat (n) step(1'b0, 0, e);
  endtask

  task automatic do_reset();
    ev_valid = 1'b0;
    ena      = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lit(input string name, input int exp);
    chk(name, int'(I_syn), exp);
    chk({name, "_model"}, m_acc, exp);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; ev_valid = 1'b0; ev_weight = '0;
    repeat (2) @(negedge clk);
    chk("reset_I_syn", int'(I_syn), 0);
    chk("reset_ev_ready", int'(ev_ready), 1);
    rst_n = 1'b1;

    // Mid-stream asynchronous reset with acc=57 and three events queued
    step(1'b1, 57, 1'b1);
    step(1'b0, 0, 1'b1);
    lit("pre_rst_acc", 57);
    step(1'b1, 5, 1'b0);
    step(1'b1, 6, 1'b0);
    step(1'b1, 7, 1'b0);
    chk("pre_rst_count", int'(ev_count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_I_syn", int'(I_syn), 0);
    chk("async_rst_count", int'(ev_count), 0);
    chk("async_rst_ready", int'(ev_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single event of weight 40, then decay ticks
    step(1'b1, 40, 1'b1);
    step(1'b0, 0, 1'b1);
    lit("single_40", 40);
    idle(14, 1'b1); lit("decay_35", 35);
    idle(16, 1'b1); lit("decay_31", 31);
    idle(16, 1'b1); lit("decay_28", 28);
    idle(16, 1'b1); lit("decay_25", 25);

    // Positive saturation
    do_reset();
    step(1'b1, 100, 1'b1);
    step(1'b1, 100, 1'b1);
    lit("sat_pos_100", 100);
    chk("sat_pos_nosat", int'(sat), 0);
    step(1'b1, 100, 1'b1);
    lit("sat_pos_127a", 127);
    chk("sat_pos_pulse_a", int'(sat), 1);
    step(1'b1, 100, 1'b1);
    lit("sat_pos_127b", 127);
    chk("sat_pos_pulse_b", int'(sat), 1);
    step(1'b1, 100, 1'b1);
    idle(2, 1'b1);
    lit("sat_pos_hold", 127);
    chk("sat_pos_clear", int'(sat), 0);

    // Negative saturation
    do_reset();
    step(1'b1, -100, 1'b1);
    step(1'b1, -100, 1'b1);
    lit("sat_neg_m100", -100);
    step(1'b0, 0, 1'b1);
    lit("sat_neg_m128", -128);
    chk("sat_neg_pulse", int'(sat), 1);
    step(1'b0, 0, 1'b1);
    chk("sat_neg_clear", int'(sat), 0);

    // Backpressure with ena low, then drain
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, i, 1'b0);
      if (i == 3) chk("bp_ready_3", int'(ev_ready), 1);
      if (i == 4) chk("bp_ready_4", int'(ev_ready), 0);
    end
    chk("bp_count_full", int'(ev_count), 4);
    lit("bp_frozen", 0);
    step(1'b0, 0, 1'b1);
    chk("bp_count_3", int'(ev_count), 3);
    chk("bp_ready_rise", int'(ev_ready), 1);
    lit("bp_first_pop", 1);
    idle(3, 1'b1);
    chk("bp_drained", int'(ev_count), 0);
    lit("bp_sum", 10);

    // Decay of +3 to zero
    do_reset();
    step(1'b1, 3, 1'b1);
    step(1'b0, 0, 1'b1);
    lit("dz_p3", 3);
    idle(14, 1'b1); lit("dz_p2", 2);
    idle(16, 1'b1); lit("dz_p1", 1);
    idle(16, 1'b1); lit("dz_p0", 0);
    idle(16, 1'b1); lit("dz_p0_hold", 0);

    // Decay of -3 to zero
    do_reset();
    step(1'b1, -3, 1'b1);
    step(1'b0, 0, 1'b1);
    lit("dz_m3", -3);
    idle(14, 1'b1); lit("dz_m2", -2);
    idle(16, 1'b1); lit("dz_m1", -1);
    idle(16, 1'b1); lit("dz_m0", 0);
    idle(16, 1'b1); lit("dz_m0_hold", 0);

    // Tick and pop on the same edge, then an ena-low freeze
    do_reset();
    step(1'b1, 80, 1'b1);
    step(1'b0, 0, 1'b1);
    lit("sim_80", 80);
    idle(12, 1'b1);
    step(1'b1, 10, 1'b1);
    lit("sim_pre", 80);
    step(1'b0, 0, 1'b1);
    lit("sim_tick_pop", 80);
    idle(5, 1'b0);
    lit("sim_frozen", 80);
    idle(15, 1'b1);
    lit("sim_phase_held", 80);
    idle(1, 1'b1);
    lit("sim_next_tick", 70);

    idle(2, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
